// File: rtl/sccpu_trace_buffer.sv
// sccpu_trace_buffer
//   Trace capture on the sccpu debug outputs. While armed, one
//   {pc, inst, aluout, memout} sample is written per clock into a circular
//   buffer. A pc match freezes the buffer POST_TRIG samples later. The window
//   is then replayed oldest-first over a valid/ready read port.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no capture, waiting for arm
//   ARMED | capturing every clock, watching for pc == trig_pc
//   POST  | capturing the post-trigger samples
//   DONE  | frozen, replaying the window on rd_valid/rd_ready
//
// Ports
//   clk, clrn                 clock, synchronous active-low reset
//   pc, inst, aluout, memout  CPU debug outputs (sample inputs)
//   arm                       start capture (IDLE only)
//   trig_en, trig_pc          pc-match trigger enable / address
//   rd_valid, rd_ready        read port handshake
//   rd_data                   {pc, inst, aluout, memout}, pc in [127:96]
//   state                     IDLE=0, ARMED=1, POST=2, DONE=3
//   count                     stored entries, saturates at DEPTH
//   done                      one-cycle pulse after the last entry is read
module sccpu_trace_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int POST_TRIG  = 8
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [31:0]           pc,
    input  logic [31:0]           inst,
    input  logic [31:0]           aluout,
    input  logic [31:0]           memout,
    input  logic                  arm,
    input  logic                  trig_en,
    input  logic [31:0]           trig_pc,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [127:0]          rd_data,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LP_DEPTH   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LP_CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] LP_POST    = DEPTH_LOG2'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [127:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2-1:0]  r_post;
    logic [DEPTH_LOG2:0]    r_count;
    logic [DEPTH_LOG2:0]    r_rd_idx;   // entries presented so far
    logic                   r_rd_valid;
    logic [127:0]           r_rd_data;
    logic                   r_done;

    logic                   w_capture;
    logic                   w_trig;
    logic                   w_xfer;
    logic                   w_last_xfer;
    logic [DEPTH_LOG2-1:0]  w_oldest;
    logic [127:0]           w_sample;

    assign w_sample    = {pc, inst, aluout, memout};
    assign w_capture   = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_trig      = trig_en && (pc == trig_pc);
    assign w_xfer      = r_rd_valid && rd_ready;
    assign w_last_xfer = w_xfer && (r_rd_idx == r_count);
    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign w_oldest    = (r_count == LP_DEPTH) ? r_wr_ptr : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_next = S_ARMED;
            S_ARMED: if (w_trig) w_next = (POST_TRIG == 0) ? S_DONE : S_POST;
            S_POST:  if (r_post == LP_PTR_ONE) w_next = S_DONE;
            S_DONE:  if (w_last_xfer) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Buffer storage carries no reset; contents are only read after capture.
    always_ff @(posedge clk) begin
        if (clrn && w_capture) r_mem[r_wr_ptr] <= w_sample;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_post     <= '0;
            r_count    <= '0;
            r_rd_idx   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_count  <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                S_ARMED, S_POST: begin
                    r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
                    if (r_count != LP_DEPTH) r_count <= r_count + LP_CNT_ONE;
                    if (r_state == S_ARMED) begin
                        if (w_trig) r_post <= LP_POST;
                    end else begin
                        r_post <= r_post - LP_PTR_ONE;
                    end
                end
                S_DONE: begin
                    // rd_valid low in DONE only happens on the first cycle.
                    if (!r_rd_valid) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= r_mem[w_oldest];
                        r_rd_ptr   <= w_oldest + LP_PTR_ONE;
                        r_rd_idx   <= LP_CNT_ONE;
                    end else if (w_last_xfer) begin
                        r_rd_valid <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (w_xfer) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                        r_rd_ptr  <= r_rd_ptr + LP_PTR_ONE;
                        r_rd_idx  <= r_rd_idx + LP_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign state    = r_state;
    assign count    = r_count;
    assign done     = r_done;

endmodule

// File: tb/tb_sccpu_trace_buffer.sv
module tb_sccpu_trace_buffer;

    logic         clk = 1'b0;
    logic         clrn;
    logic [31:0]  pc, inst, aluout, memout, trig_pc;
    logic         arm, arm0, trig_en, rd_ready;

    logic         rd_valid, done, rd_valid0, done0;
    logic [127:0] rd_data, rd_data0;
    logic [1:0]   state, state0;
    logic [4:0]   count, count0;

    always #5 clk = ~clk;

    sccpu_trace_buffer #(.DEPTH_LOG2(4), .POST_TRIG(8)) dut (
        .clk(clk), .clrn(clrn), .pc(pc), .inst(inst), .aluout(aluout),
        .memout(memout), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .state(state), .count(count), .done(done)
    );

    sccpu_trace_buffer #(.DEPTH_LOG2(4), .POST_TRIG(0)) dut0 (
        .clk(clk), .clrn(clrn), .pc(pc), .inst(inst), .aluout(aluout),
        .memout(memout), .arm(arm0), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0),
        .state(state0), .count(count0), .done(done0)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] exp0_q[$];
    int           exp_count, exp0_count;
    int           n_done = 0, n_done0 = 0;

    logic [31:0]  s_pc[64], s_inst[64], s_alu[64], s_mem[64];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Ready generator: 0 = always ready, 1 = fixed stall pattern, 2 = random.
    int rdy_mode = 0;
    initial begin
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int idx = 0;
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin rd_ready = pat[idx % 6]; idx++; end
                2: rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b1;
            endcase
        end
    end

    // Monitor for the POST_TRIG=8 instance.
    bit           pend_done = 0;
    bit           prev_valid = 0, prev_ready = 0;
    logic [127:0] prev_data;
    always @(negedge clk) begin
        if (pend_done) begin
            chk("done_pulse", {127'd0, done}, 128'd1);
            chk("rd_valid_after_last", {127'd0, rd_valid}, 128'd0);
            chk("state_after_last", {126'd0, state}, 128'd0);
            chk("final_count", {123'd0, count}, 128'(exp_count));
            pend_done = 0;
            n_done++;
        end else if (done) begin
            chk("spurious_done", {127'd0, done}, 128'd0);
        end
        if (prev_valid && !prev_ready) begin
            chk("stall_valid", {127'd0, rd_valid}, 128'd1);
            chk("stall_data", rd_data, prev_data);
        end
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", rd_data, 128'd0 ^ ~rd_data);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
                if (exp_q.size() == 0) pend_done = 1;
            end
        end
        prev_valid = rd_valid;
        prev_ready = rd_ready;
        prev_data  = rd_data;
    end

    // Monitor for the POST_TRIG=0 instance.
    bit pend_done0 = 0;
    always @(negedge clk) begin
        if (pend_done0) begin
            chk("done0_pulse", {127'd0, done0}, 128'd1);
            chk("state0_after_last", {126'd0, state0}, 128'd0);
            chk("final_count0", {123'd0, count0}, 128'(exp0_count));
            pend_done0 = 0;
            n_done0++;
        end
        if (rd_valid0 && rd_ready) begin
            if (exp0_q.size() == 0) begin
                chk("unexpected_entry0", rd_data0, ~rd_data0);
            end else begin
                chk("rd_data0", rd_data0, exp0_q.pop_front());
                if (exp0_q.size() == 0) pend_done0 = 1;
            end
        end
    end

    // Builds nsamp samples (pc = 4*k), predicts the frozen window from the
    // trigger rule, queues it, then arms the chosen instance and plays the
    // samples one per clock with the first sample on the first armed edge.
    task automatic run_capture(input logic [31:0] tpc, input logic ten, input int nsamp,
                               input bit push, input bit which);
        int post = which ? 0 : 8;
        int t = -1;
        int last, first;
        for (int k = 0; k < nsamp; k++) begin
            s_pc[k]   = 32'(4 * k);
            s_inst[k] = $urandom;
            s_alu[k]  = $urandom;
            s_mem[k]  = $urandom;
            if (t < 0 && ten && s_pc[k] == tpc) t = k;
        end
        if (push && t >= 0) begin
            last  = t + post;
            first = (last >= 16) ? last - 15 : 0;
            for (int k = first; k <= last; k++) begin
                if (which) exp0_q.push_back({s_pc[k], s_inst[k], s_alu[k], s_mem[k]});
                else       exp_q.push_back({s_pc[k], s_inst[k], s_alu[k], s_mem[k]});
            end
            if (which) exp0_count = last - first + 1;
            else       exp_count  = last - first + 1;
        end
        @(posedge clk); #1;
        trig_pc = tpc;
        trig_en = ten;
        if (which) arm0 = 1'b1; else arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        arm0 = 1'b0;
        for (int k = 0; k < nsamp; k++) begin
            pc = s_pc[k]; inst = s_inst[k]; aluout = s_alu[k]; memout = s_mem[k];
            @(posedge clk); #1;
        end
        pc = 32'hFFFF_FFF0;
    endtask

    task automatic wait_readout(input bit which, input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if ((which ? n_done0 : n_done) >= target) break;
            @(posedge clk);
        end
        n_checks++;
        if ((which ? n_done0 : n_done) < target) begin
            n_errors++;
            $display("FAIL readout_timeout: got %0d readouts expected %0d", which ? n_done0 : n_done, target);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        clrn = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
        clrn = 1'b1;
    endtask

    initial begin
        int t, nrun;
        clrn = 1'b0; arm = 1'b0; arm0 = 1'b0; trig_en = 1'b0; trig_pc = '0;
        pc = '0; inst = '0; aluout = '0; memout = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_state", {126'd0, state}, 128'd0);
        chk("reset_count", {123'd0, count}, 128'd0);
        chk("reset_rd_valid", {127'd0, rd_valid}, 128'd0);
        chk("reset_rd_data", rd_data, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        clrn = 1'b1;

        nrun = 0;
        rdy_mode = 0;
        run_capture(32'h40, 1'b1, 25, 1'b1, 1'b0);
        wait_readout(1'b0, ++nrun, 200);
        run_capture(32'h8, 1'b1, 11, 1'b1, 1'b0);
        wait_readout(1'b0, ++nrun, 200);

        rdy_mode = 1;
        run_capture(32'h40, 1'b1, 25, 1'b1, 1'b0);
        wait_readout(1'b0, ++nrun, 400);

        rdy_mode = 2;
        repeat (4) begin
            t = $urandom_range(0, 30);
            run_capture(32'(4 * t), 1'b1, t + 9, 1'b1, 1'b0);
            wait_readout(1'b0, ++nrun, 400);
        end
        rdy_mode = 0;

        run_capture(32'h8, 1'b0, 40, 1'b0, 1'b0);
        chk("notrig_state", {126'd0, state}, 128'd1);
        chk("notrig_count", {123'd0, count}, 128'd16);
        chk("notrig_rd_valid", {127'd0, rd_valid}, 128'd0);
        do_reset(2);

        run_capture(32'h8, 1'b1, 5, 1'b0, 1'b0);
        chk("mid_post_state", {126'd0, state}, 128'd2);
        do_reset(2);
        chk("post_reset_state", {126'd0, state}, 128'd0);
        chk("post_reset_count", {123'd0, count}, 128'd0);
        chk("post_reset_rd_valid", {127'd0, rd_valid}, 128'd0);
        chk("post_reset_done", {127'd0, done}, 128'd0);
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        chk("rearm_state", {126'd0, state}, 128'd1);
        do_reset(2);

        run_capture(32'h0, 1'b1, 1, 1'b1, 1'b1);
        wait_readout(1'b1, 1, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sccpu_trace_buffer.md
Name: sccpu_trace_buffer

Overview:
- Capture block on the sccpu debug outputs (pc, inst, aluout, memout): the consumer side of the status interface the CPU drives.
- Records one {pc, inst, aluout, memout} sample per clock into a circular buffer while armed.
- Freezes a fixed number of samples after a pc-match trigger, then replays the window oldest-first over a valid/ready read port to a host or debug bridge.

Parameters:
- DEPTH_LOG2, 4, log2 of buffer entries (DEPTH = 16).
- POST_TRIG, 8, samples captured after the trigger sample. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- clrn  in  1  synchronous active-low reset
- pc  in  32  CPU program counter
- inst  in  32  CPU current instruction
- aluout  in  32  CPU ALU result
- memout  in  32  CPU data-memory read value
- arm  in  1  start capture; honoured only in IDLE
- trig_en  in  1  enables pc-match trigger
- trig_pc  in  32  trigger address
- rd_valid  out  1  rd_data holds a valid entry
- rd_ready  in  1  host accepts entry
- rd_data  out  128  {pc, inst, aluout, memout}, pc in [127:96]
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- count  out  DEPTH_LOG2+1  stored entries, saturates at DEPTH
- done  out  1  one-cycle pulse after the last entry is read

Behaviour:
- Reset: clk edge with clrn=0 forces state=IDLE, count=0, write pointer=0, post counter=0, rd_valid=0, rd_data=0, done=0. Buffer contents are don't-care. Reset wins in every state, including mid-POST and mid-readout.
- IDLE: no capture. arm=1 at an edge -> ARMED, count=0, wr_ptr=0. arm is ignored in all other states.
- ARMED: every edge writes the current sample at wr_ptr. wr_ptr increments mod DEPTH. count increments, saturating at DEPTH.
  - If trig_en=1 and pc==trig_pc on that edge, the sample is still written (it is the trigger sample).
  - If POST_TRIG=0 the next state is DONE; otherwise the next state is POST with post counter=POST_TRIG.
- POST: every edge writes a sample and decrements the post counter. The edge that writes with counter==1 moves to DONE. Trigger inputs are ignored.
- Window: oldest entry index = (count==DEPTH) ? wr_ptr : 0. The window holds count entries and ends with the last post-trigger sample.
- DONE/readout:
  - The cycle after entering DONE, rd_valid=1 and rd_data=oldest entry (registered read, 1-cycle latency).
  - A transfer occurs on an edge with rd_valid&&rd_ready. The next edge presents the next entry, mod DEPTH.
  - While rd_valid&&!rd_ready, rd_data and rd_valid hold stable.
  - After the transfer of entry count-1: rd_valid=0, done=1 for one cycle, state=IDLE, count retains its final value until the next arm.
- No capture occurs in DONE or IDLE; CPU outputs are ignored there.
- Comparison is full 32-bit equality. No masking.

Test Plan:
- Reset: clrn=0 for 2 edges during POST -> state=0, count=0, rd_valid=0, done=0. A following arm -> state=1 on the next edge.
- Wrap capture: DEPTH_LOG2=4, POST_TRIG=8, pc=0,4,8,... one per clock, arm timed so the first captured pc=0x0, trig_en=1, trig_pc=0x40 -> DONE after pc 0x60 is captured. count=16. With rd_ready=1, 16 entries pc 0x24..0x60 in order, then done pulse, state=0.
- Early trigger: same stimulus with trig_pc=0x8 -> count=11. Readout pc 0x0..0x28, inst/aluout/memout matching the sampled values.
- Backpressure: during readout drive rd_ready 1,0,0,1,0,1... -> every entry is delivered exactly once, in order. rd_data is unchanged across stalled cycles.
- No trigger: trig_en=0, 40 cycles armed -> state stays 1, count saturates at 16, rd_valid stays 0.
- POST_TRIG=0 and trig_pc equal to the first captured pc -> count=1, one entry read (pc=0x0), done pulses.
